// File: rtl/ddr3_frame_writer.sv
// Avalon-MM write master for the DDR3 frame buffer: packs 32-bit pixels into
// 128-bit beats, queues them in a small FIFO and writes them out in fixed bursts.
module ddr3_frame_writer #(
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 26
) (
  input  logic              ddr3_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [19:0]       frame_beats,
  input  logic              pix_valid,
  input  logic [31:0]       pix_data,
  output logic              pix_ready,
  output logic              busy,
  output logic              done,
  output logic [19:0]       beats_written,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_burstbegin,
  output logic [2:0]        ddr3_avl_size,
  output logic              ddr3_avl_write_req,
  output logic [127:0]      ddr3_avl_wr_data,
  output logic [ADDR_W-1:0] ddr3_avl_addr
);

  localparam int              PTR_W     = $clog2(FIFO_DEPTH);
  localparam int              CNT_W     = PTR_W + 1;
  localparam logic [2:0]      BURST_SZ  = 3'(BURST_LEN);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
  state_t state, state_nxt;

  logic [19:0]      frame_q, beats_packed, rem;
  logic [1:0]       pix_cnt;
  logic [95:0]      pack_q;
  logic [127:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [2:0]       burst_cnt, size_nxt;
  logic             start_ok, launch, finish, accept, last_beat, pix_fire, push;

  assign accept    = ddr3_avl_write_req && ddr3_avl_ready;
  assign last_beat = accept && (burst_cnt == ddr3_avl_size - 3'd1);
  // Depends only on registered state, never on pix_valid.
  assign pix_ready = busy && (fifo_count != FIFO_FULL) && (beats_packed < frame_q);
  assign pix_fire  = pix_valid && pix_ready;
  assign push      = pix_fire && (pix_cnt == 2'd3);
  assign rem       = frame_q - beats_written;
  assign finish    = (state == S_WAIT) && (state_nxt == S_DONE);

  always_ff @(posedge ddr3_clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    launch    = 1'b0;
    size_nxt  = BURST_SZ;
    unique case (state)
      S_IDLE: if (start) begin
        start_ok  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rem == 20'd0) begin
          state_nxt = S_DONE;
        end else if (rem >= 20'(BURST_LEN)) begin
          if (fifo_count >= CNT_W'(BURST_LEN)) begin
            launch    = 1'b1;
            state_nxt = S_BURST;
          end
        end else if (20'(fifo_count) >= rem) begin
          launch    = 1'b1;
          size_nxt  = rem[2:0];
          state_nxt = S_BURST;
        end
      end
      S_BURST: if (last_beat) state_nxt = S_WAIT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: beat storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge ddr3_clk) begin
    if (push) mem[wr_ptr] <= {pix_data, pack_q};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge ddr3_clk or posedge reset) begin
    if (reset) begin
      busy                <= 1'b0;
      done                <= 1'b0;
      frame_q             <= '0;
      beats_written       <= '0;
      beats_packed        <= '0;
      pix_cnt             <= '0;
      pack_q              <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_count          <= '0;
      burst_cnt           <= '0;
      ddr3_avl_burstbegin <= 1'b0;
      ddr3_avl_size       <= '0;
      ddr3_avl_write_req  <= 1'b0;
      ddr3_avl_wr_data    <= '0;
      ddr3_avl_addr       <= '0;
    end else begin
      done <= finish;

      if (pix_fire) begin
        pix_cnt <= pix_cnt + 2'd1;
        unique case (pix_cnt)
          2'd0:    pack_q[31:0]  <= pix_data;
          2'd1:    pack_q[63:32] <= pix_data;
          2'd2:    pack_q[95:64] <= pix_data;
          default: ;
        endcase
      end
      if (push) begin
        beats_packed <= beats_packed + 20'd1;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      unique case ({push, accept})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase

      if (accept) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        beats_written <= beats_written + 20'd1;
      end

      // Burst outputs only move on launch or on an accepted beat, so a stall holds them.
      if (launch) begin
        ddr3_avl_write_req  <= 1'b1;
        ddr3_avl_burstbegin <= 1'b1;
        ddr3_avl_size       <= size_nxt;
        ddr3_avl_wr_data    <= mem[rd_ptr];
        burst_cnt           <= '0;
      end else if (accept) begin
        ddr3_avl_burstbegin <= 1'b0;
        burst_cnt           <= burst_cnt + 3'd1;
        if (last_beat) begin
          ddr3_avl_write_req <= 1'b0;
          ddr3_avl_addr      <= ddr3_avl_addr + ADDR_W'(ddr3_avl_size);
        end else begin
          ddr3_avl_wr_data <= mem[rd_ptr + PTR_W'(1)];
        end
      end

      if (start_ok) begin
        busy          <= 1'b1;
        frame_q       <= frame_beats;
        beats_written <= '0;
        beats_packed  <= '0;
        pix_cnt       <= '0;
        ddr3_avl_addr <= base_addr;
      end else if (finish) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Directed bench for ddr3_frame_writer: a cycle-stepped pixel source and Avalon
// sink record every accepted beat and compare against hand-derived expectations.
module tb_ddr3_frame_writer;

  localparam int BL = 4;

  logic         ddr3_clk, reset, start;
  logic [25:0]  base_addr;
  logic [19:0]  frame_beats;
  logic         pix_valid, pix_ready, busy, done;
  logic [31:0]  pix_data;
  logic [19:0]  beats_written;
  logic         ddr3_avl_ready, ddr3_avl_burstbegin, ddr3_avl_write_req;
  logic [2:0]   ddr3_avl_size;
  logic [127:0] ddr3_avl_wr_data;
  logic [25:0]  ddr3_avl_addr;

  ddr3_frame_writer #(.BURST_LEN(4), .FIFO_DEPTH(16), .ADDR_W(26)) dut (
    .ddr3_clk(ddr3_clk), .reset(reset), .start(start), .base_addr(base_addr),
    .frame_beats(frame_beats), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy), .done(done), .beats_written(beats_written),
    .ddr3_avl_ready(ddr3_avl_ready), .ddr3_avl_burstbegin(ddr3_avl_burstbegin),
    .ddr3_avl_size(ddr3_avl_size), .ddr3_avl_write_req(ddr3_avl_write_req),
    .ddr3_avl_wr_data(ddr3_avl_wr_data), .ddr3_avl_addr(ddr3_avl_addr)
  );

  initial ddr3_clk = 1'b0;
  always #5 ddr3_clk = ~ddr3_clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0, start_cyc = -1, start2_cyc = -1;
  logic [25:0] base1, base2;
  logic [19:0] fr1, fr2;
  int frame_n;
  int pix_next, pix_end, pix_acc;
  int ready_mode, stall_cnt, stall_total;
  int acc_count, last_acc_cyc, done_cnt, done_cyc, wreq_cnt, bb_total;
  int stab_err, gap_err;
  bit prev_stall, gap_pend;
  logic [127:0] sv_data;
  logic [25:0]  sv_addr;
  logic [2:0]   sv_size;
  logic         sv_bb;
  logic [127:0] rec_data [64];
  logic [25:0]  rec_addr [64];
  logic [2:0]   rec_size [64];
  logic         rec_bb   [64];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_beat(input int p0);
    return {32'(p0 + 3), 32'(p0 + 2), 32'(p0 + 1), 32'(p0)};
  endfunction

  task automatic clear_stats();
    acc_count = 0; pix_acc = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1;
    wreq_cnt = 0; bb_total = 0; stab_err = 0; gap_err = 0; stall_cnt = 0;
    stall_total = 0; prev_stall = 0; gap_pend = 0;
  endtask

  // One clock: drive inputs at the falling edge, observe, then cross the rising edge.
  task automatic cycle();
    @(negedge ddr3_clk);
    if (cyc == start_cyc) begin
      start = 1'b1; base_addr = base1; frame_beats = fr1;
    end else if (cyc == start2_cyc) begin
      start = 1'b1; base_addr = base2; frame_beats = fr2;
    end else begin
      start = 1'b0;
    end
    pix_valid = (pix_next < pix_end);
    pix_data  = 32'(pix_next);
    case (ready_mode)
      0: ddr3_avl_ready = 1'b1;
      1: ddr3_avl_ready = 1'b0;
      default: begin
        if (ddr3_avl_write_req && stall_cnt < 3 && (acc_count % 2) == 0) begin
          ddr3_avl_ready = 1'b0;
          stall_cnt++;
          stall_total++;
        end else begin
          ddr3_avl_ready = 1'b1;
        end
      end
    endcase
    #1;
    if (prev_stall && (ddr3_avl_write_req !== 1'b1 || ddr3_avl_wr_data !== sv_data ||
        ddr3_avl_addr !== sv_addr || ddr3_avl_size !== sv_size || ddr3_avl_burstbegin !== sv_bb))
      stab_err++;
    if (gap_pend) begin
      if (ddr3_avl_write_req) gap_err++;
      gap_pend = 0;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ddr3_avl_write_req) wreq_cnt++;
    if (pix_valid && pix_ready) begin pix_next++; pix_acc++; end
    if (ddr3_avl_write_req && ddr3_avl_ready) begin
      rec_data[acc_count] = ddr3_avl_wr_data;
      rec_addr[acc_count] = ddr3_avl_addr;
      rec_size[acc_count] = ddr3_avl_size;
      rec_bb[acc_count]   = ddr3_avl_burstbegin;
      if (ddr3_avl_burstbegin) bb_total++;
      acc_count++;
      last_acc_cyc = cyc;
      stall_cnt = 0;
      if ((acc_count % BL) == 0 || acc_count == frame_n) gap_pend = 1;
    end
    prev_stall = ddr3_avl_write_req && !ddr3_avl_ready;
    sv_data = ddr3_avl_wr_data; sv_addr = ddr3_avl_addr;
    sv_size = ddr3_avl_size;    sv_bb   = ddr3_avl_burstbegin;
    @(posedge ddr3_clk);
    cyc++;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done_seen"}, 128'(done_cnt > 0), 128'(1));
    repeat (3) cycle();
  endtask

  task automatic check_frame(input string tag, input int n, input logic [25:0] base, input int p0);
    chk({tag, "_beats"}, 128'(acc_count), 128'(n));
    for (int i = 0; i < n && i < acc_count; i++) begin
      int off = (i / BL) * BL;
      int r   = n - off;
      logic [25:0] ea = base + 26'(off);
      chk($sformatf("%s_b%0d_data", tag, i), rec_data[i], exp_beat(p0 + 4 * i));
      chk($sformatf("%s_b%0d_addr", tag, i), 128'(rec_addr[i]), 128'(ea));
      chk($sformatf("%s_b%0d_size", tag, i), 128'(rec_size[i]), 128'((r >= BL) ? BL : r));
      chk($sformatf("%s_b%0d_bb", tag, i), 128'(rec_bb[i]), 128'((i % BL) == 0));
    end
  endtask

  task automatic begin_frame(input logic [25:0] b, input logic [19:0] n, input int p0, input int plimit);
    clear_stats();
    base1 = b; fr1 = n; frame_n = int'(n);
    start_cyc = cyc; start2_cyc = -1;
    pix_next = p0; pix_end = plimit;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; frame_beats = '0;
    pix_valid = 1'b0; pix_data = '0; ddr3_avl_ready = 1'b0;
    ready_mode = 0; pix_next = 0; pix_end = 0;
    clear_stats();
    repeat (3) @(posedge ddr3_clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_pix_ready", 128'(pix_ready), 128'(0));
    chk("rst_write_req", 128'(ddr3_avl_write_req), 128'(0));
    chk("rst_burstbegin", 128'(ddr3_avl_burstbegin), 128'(0));
    chk("rst_addr", 128'(ddr3_avl_addr), 128'(0));
    chk("rst_beats_written", 128'(beats_written), 128'(0));
    @(negedge ddr3_clk);
    reset = 1'b0;

    // Two full bursts from 0x100, pixels 0..31, no stalls.
    ready_mode = 0;
    begin_frame(26'h100, 20'd8, 0, 32);
    cycle();
    #1;
    chk("t1_busy_after_start", 128'(busy), 128'(1));
    run_until_done("t1", 300);
    check_frame("t1", 8, 26'h100, 0);
    chk("t1_first_beat", rec_data[0], {32'd3, 32'd2, 32'd1, 32'd0});
    chk("t1_burstbegins", 128'(bb_total), 128'(2));
    chk("t1_done_count", 128'(done_cnt), 128'(1));
    chk("t1_beats_written", 128'(beats_written), 128'(8));
    chk("t1_busy_end", 128'(busy), 128'(0));
    chk("t1_gap", 128'(gap_err), 128'(0));

    // Tail burst: 6 beats, extra pixels offered beyond the frame.
    begin_frame(26'h200, 20'd6, 100, 140);
    run_until_done("t2", 300);
    check_frame("t2", 6, 26'h200, 100);
    chk("t2_pix_accepted", 128'(pix_acc), 128'(24));
    chk("t2_done_latency", 128'(done_cyc - last_acc_cyc), 128'(2));
    chk("t2_gap", 128'(gap_err), 128'(0));

    // Three-cycle stalls on every other beat, base wraps past 2^26.
    ready_mode = 2;
    begin_frame(26'h3FFFFFC, 20'd8, 200, 232);
    run_until_done("t3", 400);
    check_frame("t3", 8, 26'h3FFFFFC, 200);
    chk("t3_stall_cycles", 128'(stall_total), 128'(12));
    chk("t3_stable", 128'(stab_err), 128'(0));
    chk("t3_wrapped_addr", 128'(rec_addr[4]), 128'(0));
    chk("t3_beats_written", 128'(beats_written), 128'(8));

    // Controller stuck: FIFO fills to 16 beats, then release.
    ready_mode = 1;
    begin_frame(26'h1000, 20'd20, 300, 380);
    repeat (150) cycle();
    chk("t4_pix_held", 128'(pix_acc), 128'(64));
    chk("t4_pix_ready_low", 128'(pix_ready), 128'(0));
    chk("t4_write_req_waiting", 128'(ddr3_avl_write_req), 128'(1));
    chk("t4_none_written", 128'(beats_written), 128'(0));
    ready_mode = 0;
    run_until_done("t4", 400);
    check_frame("t4", 20, 26'h1000, 300);
    chk("t4_pix_total", 128'(pix_acc), 128'(80));
    chk("t4_beats_written", 128'(beats_written), 128'(20));
    chk("t4_stable", 128'(stab_err), 128'(0));

    // Start pulsed again mid-frame must be ignored.
    begin_frame(26'h500, 20'd4, 600, 616);
    base2 = 26'h900; fr2 = 20'd12; start2_cyc = cyc + 5;
    run_until_done("t5", 300);
    check_frame("t5", 4, 26'h500, 600);
    chk("t5_done_count", 128'(done_cnt), 128'(1));
    chk("t5_beats_written", 128'(beats_written), 128'(4));

    // Zero-length frame: done two cycles after start, no write traffic.
    begin_frame(26'h2000, 20'd0, 0, 0);
    run_until_done("t5z", 10);
    chk("t5z_done_latency", 128'(done_cyc - start_cyc), 128'(2));
    chk("t5z_no_write", 128'(wreq_cnt), 128'(0));
    chk("t5z_beats_cleared", 128'(beats_written), 128'(0));

    // Reset while the second beat of a burst is presented.
    begin_frame(26'h40, 20'd8, 700, 732);
    begin
      int n = 0;
      while (acc_count < 1 && n < 200) begin
        cycle();
        n++;
      end
    end
    chk("t6_first_beat_taken", 128'(acc_count), 128'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_write_req", 128'(ddr3_avl_write_req), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_burstbegin", 128'(ddr3_avl_burstbegin), 128'(0));
    @(negedge ddr3_clk);
    reset = 1'b0;
    begin_frame(26'h700, 20'd4, 500, 516);
    run_until_done("t6", 300);
    check_frame("t6", 4, 26'h700, 500);
    chk("t6_done_count", 128'(done_cnt), 128'(1));
    chk("t6_beats_written", 128'(beats_written), 128'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
